// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4 -- receive-side 1:4 time-division demultiplexer.
//
// Rebuilds four parallel channels from a TDM stream whose slots rotate
// 0,1,2,3. A sync strobe marks slot 0. Samples for slots 0..2 are parked in
// staging registers. On the slot-3 sample, all four channel outputs are
// loaded together, so d0..d3 always hold one coherent frame.
//
// Parameters:
//   WIDTH       bits per slot sample / output channel
//   SYNC_CHECK  1: a missing sync at slot 0 while locked is an error and
//                  forces a re-hunt
//               0: freewheel once locked
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (dominates enable/sync)
//   enable       sample strobe; when low all state holds and pulses drop
//   sync         marks the slot-0 sample (qualified by enable)
//   data_in      muxed sample for the current slot
//   d0..d3       demultiplexed channels, updated once per complete frame
//   sel1, sel2   MSB/LSB of the slot expected next (mux encoding)
//   frame_valid  one-cycle pulse: d0..d3 just took a complete frame
//   sync_err     one-cycle pulse: sync misplaced or missing
//   locked       high while in the LOCKED state
// -----------------------------------------------------------------------------
module tdm_demux4 #(
  parameter int WIDTH      = 1,
  parameter bit SYNC_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic             sel1,
  output logic             sel2,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_reg;
  logic [1:0]       slot_reg;            // slot expected on the next enabled edge
  logic [WIDTH-1:0] stage_reg [3];       // slots 0..2 of the frame in progress
  logic [WIDTH-1:0] chan_reg  [4];       // last complete frame
  logic             frame_valid_reg;
  logic             sync_err_reg;
  logic             locked_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= HUNT;
      slot_reg        <= 2'd0;
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      locked_reg      <= 1'b0;
      for (int i = 0; i < 3; i++) stage_reg[i] <= '0;
      for (int i = 0; i < 4; i++) chan_reg[i]  <= '0;
    end else begin
      // Pulses are single-cycle; they are re-asserted only by the cases below.
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;

      if (enable) begin
        case (state_reg)
          HUNT: begin
            // Everything is discarded until a sync marks slot 0.
            if (sync) begin
              stage_reg[0] <= data_in;
              slot_reg     <= 2'd1;
              state_reg    <= LOCKED;
              locked_reg   <= 1'b1;
            end
          end

          LOCKED: begin
            if (sync && (slot_reg != 2'd0)) begin
              // Early sync: drop the partial frame and realign so that
              // this sample becomes slot 0 of a new frame.
              sync_err_reg <= 1'b1;
              stage_reg[0] <= data_in;
              slot_reg     <= 2'd1;
            end else if ((slot_reg == 2'd0) && !sync && SYNC_CHECK) begin
              // Sync expected but absent: alignment can no longer be
              // trusted, so go back to hunting.
              sync_err_reg <= 1'b1;
              state_reg    <= HUNT;
              locked_reg   <= 1'b0;
            end else if (slot_reg == 2'd3) begin
              // Frame edge: publish all four channels in one edge.
              chan_reg[0]     <= stage_reg[0];
              chan_reg[1]     <= stage_reg[1];
              chan_reg[2]     <= stage_reg[2];
              chan_reg[3]     <= data_in;
              frame_valid_reg <= 1'b1;
              slot_reg        <= 2'd0;
            end else begin
              for (int i = 0; i < 3; i++) begin
                if (slot_reg == 2'(i)) stage_reg[i] <= data_in;
              end
              slot_reg <= slot_reg + 2'd1;
            end
          end

          default: begin
            state_reg  <= HUNT;
            slot_reg   <= 2'd0;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign d0          = chan_reg[0];
  assign d1          = chan_reg[1];
  assign d2          = chan_reg[2];
  assign d3          = chan_reg[3];
  assign sel1        = slot_reg[1];
  assign sel2        = slot_reg[0];
  assign frame_valid = frame_valid_reg;
  assign sync_err    = sync_err_reg;
  assign locked      = locked_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux4 -- self-checking bench for tdm_demux4 (WIDTH=1).
//
// Two instances share the same stimulus: dut (SYNC_CHECK=1) and dut_nc
// (SYNC_CHECK=0). A per-cycle vector table drives reset, basic frame, 16
// pattern sweep, enable gaps, misplaced sync and mid-frame reset; a frame
// scoreboard holds the expected {d0,d1,d2,d3} pushed when slot 3 is driven
// and popped when dut raises frame_valid. The missing-sync case, where the
// two instances diverge, is a hand-written sequence at the end.
// -----------------------------------------------------------------------------
module tb_tdm_demux4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, sync;
  logic [0:0] data_in;

  logic [0:0] a_d0, a_d1, a_d2, a_d3;
  logic a_sel1, a_sel2, a_fv, a_err, a_lock;
  logic [0:0] b_d0, b_d1, b_d2, b_d3;
  logic b_sel1, b_sel2, b_fv, b_err, b_lock;

  tdm_demux4 #(.WIDTH(1), .SYNC_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync), .data_in(data_in),
    .d0(a_d0), .d1(a_d1), .d2(a_d2), .d3(a_d3),
    .sel1(a_sel1), .sel2(a_sel2), .frame_valid(a_fv), .sync_err(a_err),
    .locked(a_lock)
  );

  tdm_demux4 #(.WIDTH(1), .SYNC_CHECK(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync), .data_in(data_in),
    .d0(b_d0), .d1(b_d1), .d2(b_d2), .d3(b_d3),
    .sel1(b_sel1), .sel2(b_sel2), .frame_valid(b_fv), .sync_err(b_err),
    .locked(b_lock)
  );

  typedef struct {
    logic       rst, en, sync, din;
    logic [1:0] sel;    // expected {sel1,sel2} after the edge
    logic       fv, err, lock;
    logic [3:0] d;      // expected {d0,d1,d2,d3} after the edge
    logic       push;   // push d as an expected frame when driving this vector
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] frame_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, en, sy, din, input logic [1:0] sel,
                     input logic fv, err, lock, input logic [3:0] d, input logic push);
    vec_t v;
    v.rst = rst; v.en = en; v.sync = sy; v.din = din; v.sel = sel;
    v.fv = fv; v.err = err; v.lock = lock; v.d = d; v.push = push;
    vecs.push_back(v);
  endtask

  // One locked frame, sync on slot 0; pattern p is {d0,d1,d2,d3}.
  task automatic add_frame(input logic [3:0] p, input logic [3:0] prev);
    for (int s = 0; s < 4; s++) begin
      add(1'b0, 1'b1, (s == 0), p[3-s], 2'((s + 1) % 4), (s == 3), 1'b0, 1'b1,
          (s == 3) ? p : prev, (s == 3));
    end
  endtask

  // Drive one cycle, sample #1 after the edge, and serve the frame scoreboard.
  task automatic tick(input logic rst, en, sy, din);
    @(negedge clk);
    reset = rst; enable = en; sync = sy; data_in = din;
    @(posedge clk);
    #1;
    if (a_fv) begin
      if (frame_q.size() == 0) begin
        chk("frame_unexpected", 8'd1, 8'd0);
      end else begin
        logic [3:0] e;
        e = frame_q.pop_front();
        chk("frame_data", {4'd0, a_d0, a_d1, a_d2, a_d3}, {4'd0, e});
      end
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    if (v.push) frame_q.push_back(v.d);
    tick(v.rst, v.en, v.sync, v.din);
    chk($sformatf("v%0d_sel", idx),   {6'd0, a_sel1, a_sel2}, {6'd0, v.sel});
    chk($sformatf("v%0d_fv", idx),    {7'd0, a_fv},   {7'd0, v.fv});
    chk($sformatf("v%0d_err", idx),   {7'd0, a_err},  {7'd0, v.err});
    chk($sformatf("v%0d_lock", idx),  {7'd0, a_lock}, {7'd0, v.lock});
    chk($sformatf("v%0d_d", idx),     {4'd0, a_d0, a_d1, a_d2, a_d3}, {4'd0, v.d});
    // Until the missing-sync test both instances must behave identically.
    chk($sformatf("v%0d_nc_sel", idx), {6'd0, b_sel1, b_sel2}, {6'd0, v.sel});
    chk($sformatf("v%0d_nc_fv", idx),  {7'd0, b_fv},   {7'd0, v.fv});
    chk($sformatf("v%0d_nc_lock", idx), {7'd0, b_lock}, {7'd0, v.lock});
    chk($sformatf("v%0d_nc_d", idx),   {4'd0, b_d0, b_d1, b_d2, b_d3}, {4'd0, v.d});
    $display("[TB] vec %0d rst=%0b en=%0b sync=%0b din=%0b -> sel=%0d fv=%0b err=%0b lock=%0b d=%04b",
             idx, v.rst, v.en, v.sync, v.din, {a_sel1, a_sel2}, a_fv, a_err, a_lock,
             {a_d0, a_d1, a_d2, a_d3});
  endtask

  initial begin
    logic [3:0] prev;
    reset = 1'b1; enable = 1'b1; sync = 1'b1; data_in = 1'b1;

    // Reset with sync/data active: everything stays cleared.
    add(1, 1, 1, 1, 2'd0, 0, 0, 0, 4'b0000, 0);
    add(1, 1, 1, 1, 2'd0, 0, 0, 0, 4'b0000, 0);

    // Basic frame 1,0,1,1 straight from HUNT.
    add_frame(4'b1011, 4'b0000);

    // Sweep all 16 patterns back to back.
    prev = 4'b1011;
    for (int p = 0; p < 16; p++) begin
      add_frame(4'(p), prev);
      prev = 4'(p);
    end

    // Enable gap between slot 1 and slot 2; frame 0,1,1,0.
    add(0, 1, 1, 0, 2'd1, 0, 0, 1, 4'b1111, 0);
    add(0, 1, 0, 1, 2'd2, 0, 0, 1, 4'b1111, 0);
    for (int g = 0; g < 3; g++) add(0, 0, 1, 1, 2'd2, 0, 0, 1, 4'b1111, 0);
    add(0, 1, 0, 1, 2'd3, 0, 0, 1, 4'b1111, 0);
    add(0, 1, 0, 0, 2'd0, 1, 0, 1, 4'b0110, 1);

    // Misplaced sync at slot 2 restarts the frame; new frame 1,1,0,0.
    add(0, 1, 1, 1, 2'd1, 0, 0, 1, 4'b0110, 0);
    add(0, 1, 0, 0, 2'd2, 0, 0, 1, 4'b0110, 0);
    add(0, 1, 1, 1, 2'd1, 0, 1, 1, 4'b0110, 0);
    add(0, 1, 0, 1, 2'd2, 0, 0, 1, 4'b0110, 0);
    add(0, 1, 0, 0, 2'd3, 0, 0, 1, 4'b0110, 0);
    add(0, 1, 0, 0, 2'd0, 1, 0, 1, 4'b1100, 1);

    // Reset mid-frame clears everything; HUNT then ignores unsynced samples.
    add(0, 1, 1, 1, 2'd1, 0, 0, 1, 4'b1100, 0);
    add(0, 1, 0, 1, 2'd2, 0, 0, 1, 4'b1100, 0);
    add(1, 1, 1, 1, 2'd0, 0, 0, 0, 4'b0000, 0);
    add(0, 1, 0, 1, 2'd0, 0, 0, 0, 4'b0000, 0);

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Missing sync: lock on frame 1,0,0,1, then omit the next sync.
    tick(0, 1, 1, 1);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    frame_q.push_back(4'b1001);
    tick(0, 1, 0, 1);
    chk("ms_lock_fv", {7'd0, a_fv}, 8'd1);
    chk("ms_lock_nc_fv", {7'd0, b_fv}, 8'd1);
    chk("ms_lock_nc_d", {4'd0, b_d0, b_d1, b_d2, b_d3}, 8'b1001);
    $display("[TB] missing-sync setup: frame 1001 delivered fv=%0b/%0b", a_fv, b_fv);

    tick(0, 1, 0, 0);
    chk("ms_err",     {7'd0, a_err},  8'd1);
    chk("ms_locked",  {7'd0, a_lock}, 8'd0);
    chk("ms_sel",     {6'd0, a_sel1, a_sel2}, 8'd0);
    chk("ms_fv",      {7'd0, a_fv},   8'd0);
    chk("ms_d_hold",  {4'd0, a_d0, a_d1, a_d2, a_d3}, 8'b1001);
    chk("ms_nc_err",  {7'd0, b_err},  8'd0);
    chk("ms_nc_lock", {7'd0, b_lock}, 8'd1);
    chk("ms_nc_sel",  {6'd0, b_sel1, b_sel2}, 8'd1);
    $display("[TB] missing sync: err=%0b locked=%0b | nc err=%0b locked=%0b",
             a_err, a_lock, b_err, b_lock);

    tick(0, 1, 0, 1);
    chk("ms_hunt_err",  {7'd0, a_err},  8'd0);
    chk("ms_hunt_lock", {7'd0, a_lock}, 8'd0);
    chk("ms_hunt_sel",  {6'd0, a_sel1, a_sel2}, 8'd0);
    chk("ms_nc_sel2",   {6'd0, b_sel1, b_sel2}, 8'd2);
    tick(0, 1, 0, 1);
    tick(0, 1, 0, 0);
    chk("ms_nc_fv",    {7'd0, b_fv}, 8'd1);
    chk("ms_nc_frame", {4'd0, b_d0, b_d1, b_d2, b_d3}, 8'b0110);
    chk("ms_fv_none",  {7'd0, a_fv}, 8'd0);
    chk("ms_d_final",  {4'd0, a_d0, a_d1, a_d2, a_d3}, 8'b1001);
    $display("[TB] freewheel frame: nc d=%04b fv=%0b | checked d=%04b",
             {b_d0, b_d1, b_d2, b_d3}, b_fv, {a_d0, a_d1, a_d2, a_d3});

    chk("scoreboard_empty", 8'(frame_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
